pf_lpddr3_c0_ddrphy_blk_iod_rx_align: RTL and testbench
=======================================================

# pf_lpddr3_c0_ddrphy_blk_iod_rx_align

Fabric-side receive alignment and training controller for one LPDDR3 PHY input lane. It consumes the 4-bit deserialized word an input IOD delivers each FAB_CLK and searches for correct word framing and sampling position. The search drives the IOD bit-slip and dynamic delay-line controls until a known training pattern is received cleanly for a full window. Once trained, it presents registered lane data to the read datapath. It is the receive counterpart of the transmit-only IOD lanes (CKE/CA) in the DDRPHY block.

## Interface
Parameters:
- PATTERN, 4'b0011, expected training word. All four rotations must be distinct.
- WINDOW, 16, consecutive matching words required to declare lock (2..255).
- SETTLE_CYCLES, 8, wait after any load, slip or move before comparing resumes (1..255).
- MAX_TAPS, 128, delay-line taps tried before failing (1..255).

Ports:
- FAB_CLK  in  1  fabric clock; the only clock.
- RX_SYNC_RST  in  1  synchronous, active-high reset.
- TRAIN_START  in  1  single-cycle training request.
- RX_DATA_0  in  4  deserialized word from IOD; bit 0 is oldest.
- DELAY_LINE_OUT_OF_RANGE_0  in  1  IOD delay-line range flag.
- RX_BIT_SLIP_0  out  1  one-cycle bit-slip pulse to IOD.
- DELAY_LINE_LOAD_0  out  1  one-cycle pulse; reloads the IOD delay to its static value.
- DELAY_LINE_MOVE_0  out  1  one-cycle pulse; steps the IOD delay by one tap.
- DELAY_LINE_DIRECTION_0  out  1  step direction; constant 1 (increment).
- RX_WORD  out  4  registered RX_DATA_0.
- RX_VALID  out  1  RX_WORD is trained data.
- TRAIN_BUSY / TRAIN_DONE / TRAIN_FAIL  out  1 each  status.
- TAP_CNT  out  8  taps moved since load.
- SLIP_CNT  out  2  current slip offset.
- ERR_CLR  in  1  clears ERR_CNT (only with RX_ALIGN_ERR_MON_EN).
- ERR_CNT  out  8  post-lock mismatch count (only with RX_ALIGN_ERR_MON_EN).

## Operation
- RX_DATA_0 is registered into rx_q every cycle. RX_WORD = rx_q. All comparisons use rx_q.
- States: IDLE, LOAD, SETTLE, CHECK, SLIP, MOVE, DONE, FAIL.
- IDLE: TRAIN_START → LOAD. Clears TAP_CNT, SLIP_CNT, TRAIN_DONE, TRAIN_FAIL and the match counter.
- LOAD: DELAY_LINE_LOAD_0 = 1 for one cycle → SETTLE.
- SETTLE: counts SETTLE_CYCLES cycles → CHECK. Match counter cleared.
- CHECK, per cycle:
  - rx_q == PATTERN: match counter increments. When it reaches WINDOW → DONE.
  - Mismatch with SLIP_CNT < 3 → SLIP.
  - Mismatch with SLIP_CNT == 3 → MOVE.
- SLIP: RX_BIT_SLIP_0 = 1 for one cycle, SLIP_CNT++ → SETTLE.
- MOVE:
  - If TAP_CNT == MAX_TAPS-1 → FAIL, with no pulse.
  - Otherwise DELAY_LINE_MOVE_0 = 1 for one cycle, TAP_CNT++, SLIP_CNT wraps to 0 → SETTLE.
- DELAY_LINE_OUT_OF_RANGE_0 = 1 in any busy state → FAIL on the next edge. This takes priority over all other transitions.
- DONE: TRAIN_DONE = RX_VALID = 1, held until reset or TRAIN_START. TRAIN_START here → LOAD (retrain); RX_VALID drops on that same edge.
- FAIL: TRAIN_FAIL = 1, held. TRAIN_START → LOAD.
- TRAIN_BUSY = 1 in LOAD, SETTLE, CHECK, SLIP and MOVE. TRAIN_START while busy is ignored.
- At most one of LOAD/MOVE/SLIP pulses in any cycle.

## Timing
- Reset values: every output is 0 (DELAY_LINE_DIRECTION_0 included; it becomes 1 from the first post-reset edge). State is IDLE, rx_q = 0, and all counters are 0.
- Reset mid-training takes effect at the next edge: pulses stop immediately and no further IOD commands are issued.
- RX_WORD latency is 1 cycle from RX_DATA_0.
- All outputs are registered. Pulses are exactly one FAB_CLK wide.
- Clean lock from TRAIN_START (sampled at edge 0):
  - LOAD pulse in cycle 1.
  - SETTLE in cycles 2..1+SETTLE_CYCLES.
  - CHECK for WINDOW cycles.
  - TRAIN_DONE high at cycle 2+SETTLE_CYCLES+WINDOW, which is 26 with defaults.
- Each slip or move adds 1 + SETTLE_CYCLES cycles, plus the CHECK cycles spent before the mismatch.

## Configuration
- RX_ALIGN_ERR_MON_EN defined:
  - In DONE, each cycle with rx_q != PATTERN increments ERR_CNT, saturating at 255.
  - ERR_CLR or leaving DONE clears it. ERR_CLR has priority over an increment in the same cycle.
  - ERR_CLR and ERR_CNT ports exist.
- Macro undefined: no ERR_CLR or ERR_CNT ports and no monitor logic. All other behaviour is identical.

## Test plan
- Aligned pattern 4'b0011 from reset, then TRAIN_START → one LOAD pulse at cycle 1, no slip or move pulses, TRAIN_DONE at cycle 26, TAP_CNT=0, SLIP_CNT=0, RX_WORD=4'b0011.
- Lane rotated by two bits (4'b1100), with each slip rotating the lane model → exactly 2 RX_BIT_SLIP_0 pulses, SLIP_CNT=2, DONE, TAP_CNT=0.
- Model passes only at tap 3 → pulse order is 3 slips + move, repeated ×3, then 0 slips. Final TAP_CNT=3, SLIP_CNT=0, DONE.
- Pattern never matches, MAX_TAPS=4 → 3 MOVE pulses, then TRAIN_FAIL with TAP_CNT=3. Separately, asserting out-of-range during SETTLE → FAIL on the next edge with no further pulses.
- Reset in CHECK after 1 slip → next cycle all outputs 0 and state IDLE. TRAIN_START mid-busy has no effect on the pulse sequence.
- With RX_ALIGN_ERR_MON_EN, after DONE inject 5 bad words → ERR_CNT=5. ERR_CLR → 0. Hold 300 bad words → ERR_CNT=255.

Source files
------------

// File: rtl/pf_lpddr3_c0_ddrphy_blk_iod_rx_align_if.sv
// Lane-side bus of the LPDDR3 RX alignment controller (IOD controls, lane data, training status).
// ERR_CLR / ERR_CNT are present only when RX_ALIGN_ERR_MON_EN is defined.
interface pf_lpddr3_c0_ddrphy_blk_iod_rx_align_if;
    logic       TRAIN_START;
    logic [3:0] RX_DATA_0;
    logic       DELAY_LINE_OUT_OF_RANGE_0;
    logic       RX_BIT_SLIP_0;
    logic       DELAY_LINE_LOAD_0;
    logic       DELAY_LINE_MOVE_0;
    logic       DELAY_LINE_DIRECTION_0;
    logic [3:0] RX_WORD;
    logic       RX_VALID;
    logic       TRAIN_BUSY;
    logic       TRAIN_DONE;
    logic       TRAIN_FAIL;
    logic [7:0] TAP_CNT;
    logic [1:0] SLIP_CNT;
`ifdef RX_ALIGN_ERR_MON_EN
    logic       ERR_CLR;
    logic [7:0] ERR_CNT;
`endif

    modport master (
        output TRAIN_START,
        output RX_DATA_0,
        output DELAY_LINE_OUT_OF_RANGE_0,
        input  RX_BIT_SLIP_0,
        input  DELAY_LINE_LOAD_0,
        input  DELAY_LINE_MOVE_0,
        input  DELAY_LINE_DIRECTION_0,
        input  RX_WORD,
        input  RX_VALID,
        input  TRAIN_BUSY,
        input  TRAIN_DONE,
        input  TRAIN_FAIL,
        input  TAP_CNT,
        input  SLIP_CNT
`ifdef RX_ALIGN_ERR_MON_EN
        ,
        output ERR_CLR,
        input  ERR_CNT
`endif
    );

    modport slave (
        input  TRAIN_START,
        input  RX_DATA_0,
        input  DELAY_LINE_OUT_OF_RANGE_0,
        output RX_BIT_SLIP_0,
        output DELAY_LINE_LOAD_0,
        output DELAY_LINE_MOVE_0,
        output DELAY_LINE_DIRECTION_0,
        output RX_WORD,
        output RX_VALID,
        output TRAIN_BUSY,
        output TRAIN_DONE,
        output TRAIN_FAIL,
        output TAP_CNT,
        output SLIP_CNT
`ifdef RX_ALIGN_ERR_MON_EN
        ,
        input  ERR_CLR,
        output ERR_CNT
`endif
    );
endinterface

// File: rtl/pf_lpddr3_c0_ddrphy_blk_iod_rx_align.sv
// Receive word-framing / delay-line training controller for one LPDDR3 IOD input lane.
// Define RX_ALIGN_ERR_MON_EN to add the post-lock mismatch counter (ERR_CLR / ERR_CNT).
module pf_lpddr3_c0_ddrphy_blk_iod_rx_align #(
    parameter logic [3:0] PATTERN       = 4'b0011,
    parameter int         WINDOW        = 16,
    parameter int         SETTLE_CYCLES = 8,
    parameter int         MAX_TAPS      = 128
) (
    input logic FAB_CLK,
    input logic RX_SYNC_RST,
    pf_lpddr3_c0_ddrphy_blk_iod_rx_align_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        CHECK,
        SLIP,
        MOVE,
        DONE,
        FAIL
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] rx_q;
    logic [7:0] settleCnt_q, settleCnt_d;
    logic [7:0] matchCnt_q, matchCnt_d;
    logic [7:0] tapCnt_q, tapCnt_d;
    logic [1:0] slipCnt_q, slipCnt_d;
    logic       loadPulse_q, loadPulse_d;
    logic       slipPulse_q, slipPulse_d;
    logic       movePulse_q, movePulse_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       fail_q, fail_d;
    logic       dir_q;
    logic       inBusy;
    logic       rxMatch;

    assign inBusy  = state_q inside {LOAD, SETTLE, CHECK, SLIP, MOVE};
    assign rxMatch = (rx_q == PATTERN);

    // Pulses and status are computed for the state being entered so every output is a flop.
    always_comb begin
        state_d     = state_q;
        settleCnt_d = settleCnt_q;
        matchCnt_d  = matchCnt_q;
        tapCnt_d    = tapCnt_q;
        slipCnt_d   = slipCnt_q;
        loadPulse_d = 1'b0;
        slipPulse_d = 1'b0;
        movePulse_d = 1'b0;

        if (inBusy && bus.DELAY_LINE_OUT_OF_RANGE_0) begin
            state_d = FAIL;
        end else begin
            case (state_q)
                IDLE, DONE, FAIL: begin
                    if (bus.TRAIN_START) begin
                        state_d     = LOAD;
                        loadPulse_d = 1'b1;
                        tapCnt_d    = 8'd0;
                        slipCnt_d   = 2'd0;
                        matchCnt_d  = 8'd0;
                    end
                end
                LOAD: begin
                    state_d     = SETTLE;
                    settleCnt_d = 8'd0;
                    matchCnt_d  = 8'd0;
                end
                SETTLE: begin
                    if (settleCnt_q == 8'(SETTLE_CYCLES - 1)) begin
                        state_d = CHECK;
                    end else begin
                        settleCnt_d = settleCnt_q + 8'd1;
                    end
                end
                CHECK: begin
                    if (rxMatch) begin
                        if (matchCnt_q == 8'(WINDOW - 1)) begin
                            state_d = DONE;
                        end else begin
                            matchCnt_d = matchCnt_q + 8'd1;
                        end
                    end else if (slipCnt_q != 2'd3) begin
                        state_d     = SLIP;
                        slipPulse_d = 1'b1;
                        slipCnt_d   = slipCnt_q + 2'd1;
                    end else begin
                        // The last tap is never stepped past; MOVE then falls through to FAIL.
                        state_d = MOVE;
                        if (tapCnt_q != 8'(MAX_TAPS - 1)) begin
                            movePulse_d = 1'b1;
                            tapCnt_d    = tapCnt_q + 8'd1;
                            slipCnt_d   = 2'd0;
                        end
                    end
                end
                SLIP: begin
                    state_d     = SETTLE;
                    settleCnt_d = 8'd0;
                    matchCnt_d  = 8'd0;
                end
                MOVE: begin
                    if (movePulse_q) begin
                        state_d     = SETTLE;
                        settleCnt_d = 8'd0;
                        matchCnt_d  = 8'd0;
                    end else begin
                        state_d = FAIL;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = state_d inside {LOAD, SETTLE, CHECK, SLIP, MOVE};
        done_d = (state_d == DONE);
        fail_d = (state_d == FAIL);
    end

    always_ff @(posedge FAB_CLK) begin
        if (RX_SYNC_RST) begin
            state_q     <= IDLE;
            rx_q        <= 4'd0;
            settleCnt_q <= 8'd0;
            matchCnt_q  <= 8'd0;
            tapCnt_q    <= 8'd0;
            slipCnt_q   <= 2'd0;
            loadPulse_q <= 1'b0;
            slipPulse_q <= 1'b0;
            movePulse_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            dir_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_q        <= bus.RX_DATA_0;
            settleCnt_q <= settleCnt_d;
            matchCnt_q  <= matchCnt_d;
            tapCnt_q    <= tapCnt_d;
            slipCnt_q   <= slipCnt_d;
            loadPulse_q <= loadPulse_d;
            slipPulse_q <= slipPulse_d;
            movePulse_q <= movePulse_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            dir_q       <= 1'b1;
        end
    end

    assign bus.RX_WORD                = rx_q;
    assign bus.RX_VALID               = done_q;
    assign bus.TRAIN_DONE             = done_q;
    assign bus.TRAIN_FAIL             = fail_q;
    assign bus.TRAIN_BUSY             = busy_q;
    assign bus.TAP_CNT                = tapCnt_q;
    assign bus.SLIP_CNT               = slipCnt_q;
    assign bus.DELAY_LINE_LOAD_0      = loadPulse_q;
    assign bus.RX_BIT_SLIP_0          = slipPulse_q;
    assign bus.DELAY_LINE_MOVE_0      = movePulse_q;
    assign bus.DELAY_LINE_DIRECTION_0 = dir_q;

`ifdef RX_ALIGN_ERR_MON_EN
    logic [7:0] errCnt_q, errCnt_d;

    // Counts only while locked; any exit from DONE restarts the count, clear beats increment.
    always_comb begin
        errCnt_d = errCnt_q;
        if (bus.ERR_CLR || (state_d != DONE)) begin
            errCnt_d = 8'd0;
        end else if ((state_q == DONE) && !rxMatch && (errCnt_q != 8'hFF)) begin
            errCnt_d = errCnt_q + 8'd1;
        end
    end

    always_ff @(posedge FAB_CLK) begin
        if (RX_SYNC_RST) begin
            errCnt_q <= 8'd0;
        end else begin
            errCnt_q <= errCnt_d;
        end
    end

    assign bus.ERR_CNT = errCnt_q;
`endif

endmodule

// File: tb/tb_pf_lpddr3_c0_ddrphy_blk_iod_rx_align.sv
// Self-checking bench for the RX alignment controller: a lane model reacts to slip/move/load pulses
// and a search-order model predicts pulse sequence, final counters and lock/fail cycle.
module tb_pf_lpddr3_c0_ddrphy_blk_iod_rx_align;

    localparam logic [3:0] PAT  = 4'b0011;
    localparam int         WIN  = 16;
    localparam int         SET  = 8;
    localparam int         MAXT = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pf_lpddr3_c0_ddrphy_blk_iod_rx_align_if bus();

    pf_lpddr3_c0_ddrphy_blk_iod_rx_align #(
        .PATTERN(PAT),
        .WINDOW(WIN),
        .SETTLE_CYCLES(SET),
        .MAX_TAPS(MAXT)
    ) dut (
        .FAB_CLK(clk),
        .RX_SYNC_RST(rst),
        .bus(bus)
    );

    int    errors = 0;
    int    checks = 0;
    int    laneTap;
    int    laneSlips;
    int    initRot;
    int    passTap;
    bit    laneNever;
    string seqLog;
    int    overlaps;

    function automatic logic [3:0] rotl(input logic [3:0] w, input int n);
        logic [3:0] r;
        r = w;
        for (int i = 0; i < (n % 4); i++) r = {r[2:0], r[3]};
        return r;
    endfunction

    function automatic logic [3:0] garbage();
        logic [3:0] g;
        do g = 4'($urandom_range(0, 15)); while (g == PAT);
        return g;
    endfunction

    // The lane only shows the pattern at its good tap, rotated by the slips applied so far.
    function automatic logic [3:0] lane_word();
        if (laneNever || (laneTap != passTap)) return garbage();
        return rotl(PAT, initRot + laneSlips);
    endfunction

    task automatic tick();
        int n;
        @(posedge clk);
        #1;
        n = int'(bus.DELAY_LINE_LOAD_0) + int'(bus.RX_BIT_SLIP_0) + int'(bus.DELAY_LINE_MOVE_0);
        if (n > 1) overlaps++;
        if (bus.DELAY_LINE_LOAD_0) begin
            seqLog  = {seqLog, "L"};
            laneTap = 0;
        end
        if (bus.RX_BIT_SLIP_0) begin
            seqLog    = {seqLog, "S"};
            laneSlips = laneSlips + 1;
        end
        if (bus.DELAY_LINE_MOVE_0) begin
            seqLog  = {seqLog, "M"};
            laneTap = laneTap + 1;
        end
        bus.RX_DATA_0 = lane_word();
    endtask

    task automatic setup_lane(input int rot, input int pt, input bit never);
        initRot       = rot;
        passTap       = pt;
        laneNever     = never;
        laneTap       = 0;
        laneSlips     = 0;
        seqLog        = "";
        overlaps      = 0;
        bus.RX_DATA_0 = lane_word();
    endtask

    // Search order: up to three slips per tap, then one tap step, giving up at the last tap.
    task automatic predict(output string seq, output int tap, output int slip, output bit failed,
                           output int endCycle);
        int cyc, t, s, rot;
        bit fin;
        seq = "L"; cyc = 1 + SET; t = 0; s = 0; rot = initRot; failed = 0; fin = 0; endCycle = 0;
        while (!fin) begin
            if (!laneNever && (t == passTap) && ((rot % 4) == 0)) begin
                endCycle = cyc + WIN + 1;
                fin = 1;
            end else begin
                cyc = cyc + 1;
                if (s < 3) begin
                    seq = {seq, "S"}; s++; rot++; cyc = cyc + 1 + SET;
                end else if (t == MAXT - 1) begin
                    failed = 1; endCycle = cyc + 2; fin = 1;
                end else begin
                    seq = {seq, "M"}; t++; s = 0; cyc = cyc + 1 + SET;
                end
            end
        end
        tap  = t;
        slip = s;
    endtask

    task automatic run_training(input int pokeCycle, output int endCycle, output bit timedOut);
        timedOut = 1;
        endCycle = 0;
        bus.TRAIN_START = 1'b1;
        tick();
        bus.TRAIN_START = 1'b0;
        for (int c = 1; c <= 2000; c++) begin
            if (c > 1) tick();
            bus.TRAIN_START = (c == pokeCycle);
            if (bus.TRAIN_DONE || bus.TRAIN_FAIL) begin
                endCycle = c;
                timedOut = 0;
                break;
            end
        end
        bus.TRAIN_START = 1'b0;
    endtask

    task automatic test_search(input string name, input int rot, input int pt, input bit never,
                               input int poke, output int endCycle);
        string expSeq;
        int    expTap, expSlip, expEnd;
        bit    expFail, timedOut;
        setup_lane(rot, pt, never);
        predict(expSeq, expTap, expSlip, expFail, expEnd);
        run_training(poke, endCycle, timedOut);
        checks++;
        if (timedOut) begin
            errors++;
            $display("[TB] FAIL %s_timeout: no DONE/FAIL within budget, expected end at cycle %0d", name, expEnd);
        end
        checks++;
        if (seqLog != expSeq) begin
            errors++;
            $display("[TB] FAIL %s_seq: got %s expected %s", name, seqLog, expSeq);
        end
        checks++;
        if (endCycle != expEnd) begin
            errors++;
            $display("[TB] FAIL %s_cycle: got %0d expected %0d", name, endCycle, expEnd);
        end
        checks++;
        if (bus.TAP_CNT !== 8'(expTap)) begin
            errors++;
            $display("[TB] FAIL %s_tap: got %0d expected %0d", name, bus.TAP_CNT, expTap);
        end
        checks++;
        if (bus.SLIP_CNT !== 2'(expSlip)) begin
            errors++;
            $display("[TB] FAIL %s_slip: got %0d expected %0d", name, bus.SLIP_CNT, expSlip);
        end
        checks++;
        if ({bus.TRAIN_DONE, bus.RX_VALID, bus.TRAIN_FAIL, bus.TRAIN_BUSY} !== {!expFail, !expFail, expFail, 1'b0}) begin
            errors++;
            $display("[TB] FAIL %s_status: got done/valid/fail/busy=%b%b%b%b expected %b%b%b0", name,
                     bus.TRAIN_DONE, bus.RX_VALID, bus.TRAIN_FAIL, bus.TRAIN_BUSY, !expFail, !expFail, expFail);
        end
        checks++;
        if (overlaps != 0) begin
            errors++;
            $display("[TB] FAIL %s_overlap: got %0d cycles with several pulses expected 0", name, overlaps);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.RX_BIT_SLIP_0, bus.DELAY_LINE_LOAD_0, bus.DELAY_LINE_MOVE_0, bus.DELAY_LINE_DIRECTION_0,
             bus.RX_WORD, bus.RX_VALID, bus.TRAIN_BUSY, bus.TRAIN_DONE, bus.TRAIN_FAIL,
             bus.TAP_CNT, bus.SLIP_CNT} !== 22'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: some output nonzero, word=%b tap=%0d dir=%b, expected all 0",
                     bus.RX_WORD, bus.TAP_CNT, bus.DELAY_LINE_DIRECTION_0);
        end
`ifdef RX_ALIGN_ERR_MON_EN
        checks++;
        if (bus.ERR_CNT !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_errcnt: got %0d expected 0", bus.ERR_CNT);
        end
`endif
        rst = 1'b0;
        tick();
        checks++;
        if ({bus.DELAY_LINE_DIRECTION_0, bus.TRAIN_BUSY} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL reset_release: got dir/busy=%b%b expected 10", bus.DELAY_LINE_DIRECTION_0, bus.TRAIN_BUSY);
        end
    endtask

    task automatic test_aligned();
        int endCycle;
        test_search("aligned", 0, 0, 0, 0, endCycle);
        checks++;
        if ((endCycle != 26) || (seqLog != "L")) begin
            errors++;
            $display("[TB] FAIL aligned_fixed: got cycle %0d seq %s expected 26 and L", endCycle, seqLog);
        end
        checks++;
        if (bus.RX_WORD !== PAT) begin
            errors++;
            $display("[TB] FAIL aligned_word: got %b expected %b", bus.RX_WORD, PAT);
        end
    endtask

    task automatic test_slip_two();
        int endCycle;
        test_search("slip_two", 2, 0, 0, 0, endCycle);
        checks++;
        if ((seqLog != "LSS") || (bus.SLIP_CNT !== 2'd2)) begin
            errors++;
            $display("[TB] FAIL slip_two_fixed: got seq %s slip %0d expected LSS and 2", seqLog, bus.SLIP_CNT);
        end
    endtask

    task automatic test_tap_three();
        int endCycle;
        test_search("tap_three", 3, 3, 0, 0, endCycle);
        checks++;
        if ((seqLog != "LSSSMSSSMSSSM") || (bus.TAP_CNT !== 8'd3)) begin
            errors++;
            $display("[TB] FAIL tap_three_fixed: got seq %s tap %0d expected LSSSMSSSMSSSM and 3", seqLog, bus.TAP_CNT);
        end
    endtask

    task automatic test_never();
        int endCycle;
        test_search("never", 0, 0, 1, 0, endCycle);
        checks++;
        if ((seqLog != "LSSSMSSSMSSSMSSS") || (bus.TAP_CNT !== 8'd3) || (bus.TRAIN_FAIL !== 1'b1)) begin
            errors++;
            $display("[TB] FAIL never_fixed: got seq %s tap %0d fail %b expected 3 moves, tap 3, fail 1",
                     seqLog, bus.TAP_CNT, bus.TRAIN_FAIL);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int endCycle;
        endCycle = 0;
        setup_lane(0, 0, 0);
        bus.TRAIN_START = 1'b1;
        tick();
        bus.TRAIN_START = 1'b0;
        checks++;
        if ({bus.DELAY_LINE_LOAD_0, bus.TRAIN_BUSY, bus.TRAIN_FAIL, bus.TRAIN_DONE, bus.RX_VALID} !== 5'b11000) begin
            errors++;
            $display("[TB] FAIL retrain_fail_start: got load/busy/fail/done/valid=%b%b%b%b%b expected 11000",
                     bus.DELAY_LINE_LOAD_0, bus.TRAIN_BUSY, bus.TRAIN_FAIL, bus.TRAIN_DONE, bus.RX_VALID);
        end
        for (cyc = 2; cyc <= 200; cyc++) begin
            tick();
            if (bus.TRAIN_DONE) begin
                endCycle = cyc;
                break;
            end
        end
        checks++;
        if (endCycle != 26) begin
            errors++;
            $display("[TB] FAIL retrain_fail_done: got cycle %0d expected 26", endCycle);
        end
        bus.TRAIN_START = 1'b1;
        tick();
        bus.TRAIN_START = 1'b0;
        checks++;
        if ({bus.DELAY_LINE_LOAD_0, bus.TRAIN_BUSY, bus.TRAIN_DONE, bus.RX_VALID} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL retrain_done_start: got load/busy/done/valid=%b%b%b%b expected 1100",
                     bus.DELAY_LINE_LOAD_0, bus.TRAIN_BUSY, bus.TRAIN_DONE, bus.RX_VALID);
        end
        repeat (30) tick();
        checks++;
        if ((seqLog != "LL") || (bus.TRAIN_DONE !== 1'b1)) begin
            errors++;
            $display("[TB] FAIL retrain_done_end: got seq %s done %b expected LL and 1", seqLog, bus.TRAIN_DONE);
        end
    endtask

    task automatic test_oor();
        setup_lane(0, 0, 1);
        bus.TRAIN_START = 1'b1;
        tick();
        bus.TRAIN_START = 1'b0;
        repeat (3) tick();
        bus.DELAY_LINE_OUT_OF_RANGE_0 = 1'b1;
        tick();
        bus.DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
        checks++;
        if ({bus.TRAIN_FAIL, bus.TRAIN_BUSY} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL oor_next_edge: got fail/busy=%b%b expected 10", bus.TRAIN_FAIL, bus.TRAIN_BUSY);
        end
        repeat (20) tick();
        checks++;
        if ((seqLog != "L") || (bus.TRAIN_FAIL !== 1'b1)) begin
            errors++;
            $display("[TB] FAIL oor_quiet: got seq %s fail %b expected L and 1", seqLog, bus.TRAIN_FAIL);
        end
    endtask

    task automatic test_reset_mid();
        setup_lane(3, 0, 0);
        bus.TRAIN_START = 1'b1;
        tick();
        bus.TRAIN_START = 1'b0;
        for (int c = 2; c <= 2 * (SET + 2); c++) tick();
        checks++;
        if ((seqLog != "LS") || (bus.SLIP_CNT !== 2'd1) || (bus.TRAIN_BUSY !== 1'b1)) begin
            errors++;
            $display("[TB] FAIL reset_mid_pre: got seq %s slip %0d busy %b expected LS, 1, 1",
                     seqLog, bus.SLIP_CNT, bus.TRAIN_BUSY);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.RX_BIT_SLIP_0, bus.DELAY_LINE_LOAD_0, bus.DELAY_LINE_MOVE_0, bus.DELAY_LINE_DIRECTION_0,
             bus.RX_WORD, bus.RX_VALID, bus.TRAIN_BUSY, bus.TRAIN_DONE, bus.TRAIN_FAIL,
             bus.TAP_CNT, bus.SLIP_CNT} !== 22'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_outputs: some output nonzero, slip=%0d busy=%b word=%b expected all 0",
                     bus.SLIP_CNT, bus.TRAIN_BUSY, bus.RX_WORD);
        end
        rst = 1'b0;
        repeat (30) tick();
        checks++;
        if ((seqLog != "LS") || (bus.TRAIN_BUSY !== 1'b0) || (bus.TRAIN_DONE !== 1'b0)) begin
            errors++;
            $display("[TB] FAIL reset_mid_idle: got seq %s busy %b done %b expected LS, 0, 0",
                     seqLog, bus.TRAIN_BUSY, bus.TRAIN_DONE);
        end
    endtask

    task automatic test_start_ignored();
        int endCycle;
        test_search("start_ignored", 2, 0, 0, SET + 4, endCycle);
    endtask

    task automatic test_random();
        int endCycle;
        for (int i = 0; i < 4; i++) begin
            test_search("random", $urandom_range(0, 3), $urandom_range(0, MAXT - 1), 0, 0, endCycle);
        end
    endtask

`ifdef RX_ALIGN_ERR_MON_EN
    task automatic test_err_mon();
        int endCycle;
        test_search("errmon_lock", 0, 0, 0, 0, endCycle);
        for (int i = 0; i < 5; i++) begin
            bus.RX_DATA_0 = garbage();
            @(posedge clk);
            #1;
        end
        bus.RX_DATA_0 = PAT;
        repeat (3) tick();
        checks++;
        if (bus.ERR_CNT !== 8'd5) begin
            errors++;
            $display("[TB] FAIL errmon_five: got %0d expected 5", bus.ERR_CNT);
        end
        bus.RX_DATA_0 = garbage();
        @(posedge clk);
        #1;
        bus.ERR_CLR   = 1'b1;
        bus.RX_DATA_0 = PAT;
        @(posedge clk);
        #1;
        bus.ERR_CLR = 1'b0;
        repeat (2) tick();
        checks++;
        if (bus.ERR_CNT !== 8'd0) begin
            errors++;
            $display("[TB] FAIL errmon_clear: got %0d expected 0", bus.ERR_CNT);
        end
        for (int i = 0; i < 300; i++) begin
            bus.RX_DATA_0 = garbage();
            @(posedge clk);
            #1;
        end
        bus.RX_DATA_0 = PAT;
        repeat (3) tick();
        checks++;
        if ((bus.ERR_CNT !== 8'd255) || (bus.RX_VALID !== 1'b1)) begin
            errors++;
            $display("[TB] FAIL errmon_saturate: got %0d valid %b expected 255 and 1", bus.ERR_CNT, bus.RX_VALID);
        end
        bus.TRAIN_START = 1'b1;
        tick();
        bus.TRAIN_START = 1'b0;
        checks++;
        if (bus.ERR_CNT !== 8'd0) begin
            errors++;
            $display("[TB] FAIL errmon_leave: got %0d expected 0", bus.ERR_CNT);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst                           = 1'b1;
        bus.TRAIN_START               = 1'b0;
        bus.RX_DATA_0                 = 4'd0;
        bus.DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
`ifdef RX_ALIGN_ERR_MON_EN
        bus.ERR_CLR                   = 1'b0;
`endif
        setup_lane(0, 0, 0);
        test_reset();
        test_aligned();
        test_slip_two();
        test_tap_three();
        test_never();
        test_back_to_back();
        test_oor();
        test_reset_mid();
        test_start_ignored();
        test_random();
`ifdef RX_ALIGN_ERR_MON_EN
        test_err_mon();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
